if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage: owns the fetch PC, runs single-outstanding
//   req/ack fetches to instruction memory and presents {if_pc, if_instr}
//   to the IF/ID pipeline register, which latches them when !stall.
//   Honours the same stall/flush controls as IF/ID, redirecting on flush.
//   A one-entry skid buffer absorbs a fetch that lands during a stall.
// PARAMETERS
//   RESET_PC   16'h0000  fetch address after reset
//   NOP_INSTR  16'hE000  encoding driven on if_instr when if_valid=0
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   stall        in   1   IF/ID holds; current if_* not consumed this cycle
//   flush        in   1   squash fetch; restart at redirect_pc
//   redirect_pc  in   16  new fetch address, sampled when flush=1
//   imem_req     out  1   fetch request; held with addr stable until ack
//   imem_addr    out  16  word address of the fetch
//   imem_ack     in   1   memory accepts and returns data this edge
//   imem_rdata   in   16  instruction, valid when imem_ack=1
//   if_pc        out  16  PC of presented instruction
//   if_instr     out  16  presented instruction (NOP_INSTR when invalid)
//   if_valid     out  1   if_pc/if_instr hold a real fetched instruction
// BEHAVIOUR
//   Reset (async, rst_n=0): state=S_FETCH, fetch_pc=RESET_PC, imem_req=0,
//     imem_addr=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0, skid
//     empty. imem_req rises in the first cycle after rst_n deasserts.
//   Reset mid-handshake aborts the request immediately; memory must tolerate it.
//   Consume: out reg consumed at an edge where if_valid=1 && stall=0.
//   PC: word-addressed, +1 per accepted fetch, 16-bit wrap (FFFF->0000).
//   imem_req=1 in S_FETCH and S_DROP; imem_addr=fetch_pc (S_DROP: old addr).
//   Once raised, req/addr never change until ack (except reset).
//   States:
//   S_FETCH: on ack (no flush): if out empty or consumed -> out<=data,
//     if_valid=1; else -> skid<=data, go S_FULL. fetch_pc+=1 either way.
//     No ack: if consumed and skid empty, out goes invalid (NOP).
//   S_FULL: imem_req=0. On consume: out<=skid, skid empty -> S_FETCH.
//   S_DROP: wait for ack; data discarded; on ack -> S_FETCH.
//   Flush (highest priority, overrides stall, any state): fetch_pc<=
//     redirect_pc; out and skid invalidated (if_valid=0, if_instr=NOP);
//     if req=1 && ack=0 that edge -> S_DROP, else -> S_FETCH. Ack coincident
//     with flush: data discarded, no PC increment.
//   Flush during S_DROP: latch newer redirect_pc, stay S_DROP.
//   Latency: ack at edge n -> if_* valid after edge n. Zero-wait memory
//     sustains 1 instr/cycle; order preserved, no loss or duplication.
// TESTING
//   T1 reset: rst_n=0 -> if_instr=E000, if_valid=0, imem_req=0; release ->
//      next cycle imem_req=1, imem_addr=0000.
//   T2 stream: ack every cycle, rdata=addr^16'hA5A5 -> if_pc 0,1,2,3 on
//      consecutive cycles, if_instr=A5A5,A5A4,A5A7,A5A6.
//   T3 stall 3 cycles at if_pc=2 with ack high -> instr 3 into skid,
//      imem_req=0; after release if_pc 2,3,4 in order, none lost or dup.
//   T4 ack delayed 2 cycles, flush redirect 0040 in wait -> addr held at
//      old value until ack, data dropped, then imem_addr=0040, if_valid=0.
//   T5 flush+stall same cycle, redirect 0100 -> if_valid=0, next fetch addr
//      0100; flush+ack same edge -> returned data never appears.
//   T6 redirect FFFF -> fetches FFFF then 0000; rst_n pulsed mid-wait ->
//      imem_req drops immediately, outputs return to reset values.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and feeds {if_pc, if_instr} to IF/ID.
// Latency: imem ack at edge n -> if_* valid after edge n; zero-wait memory sustains 1 instr/cycle.
// Backpressure: stall holds the output register; one fetch landing during a stall parks in a skid entry and drops imem_req.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   stall, flush            IF/ID hold / squash controls; flush overrides stall
//   redirect_pc             restart address, sampled when flush=1
//   imem_req, imem_addr     single-outstanding fetch request, stable until imem_ack
//   imem_ack, imem_rdata    memory accept + returned instruction
//   if_pc, if_instr         presented instruction (if_instr=NOP_INSTR when invalid)
//   if_valid                if_pc/if_instr hold a real fetched instruction
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hE000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding (or about to be raised after reset)
    S_FULL  = 2'd1,  // output and skid both occupied, request parked
    S_DROP  = 2'd2   // waiting out a squashed request whose data is discarded
  } state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic [15:0] skid_pc;
  logic [15:0] skid_instr;

  // A memory ack only counts while a request is actually on the bus.
  logic fetch_done;
  logic consume;
  logic [15:0] fetch_pc_inc;

  assign fetch_done   = imem_req && imem_ack;
  assign consume      = if_valid && !stall;
  assign fetch_pc_inc = fetch_pc + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      fetch_pc   <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      if_pc      <= 16'h0000;
      if_instr   <= NOP_INSTR;
      if_valid   <= 1'b0;
      skid_pc    <= 16'h0000;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      // Squash everything held locally and restart at the redirect target.
      fetch_pc <= redirect_pc;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if (imem_req && !imem_ack) begin
        // The old request is still open: keep req/addr frozen until memory
        // acks it, then throw the data away.
        state <= S_DROP;
      end else begin
        // Either nothing was outstanding or it completed this edge (its data
        // is discarded and does not advance the PC).
        state     <= S_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
      end
    end else begin
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          if (fetch_done) begin
            fetch_pc  <= fetch_pc_inc;
            imem_addr <= fetch_pc_inc;
            if (!if_valid || consume) begin
              if_pc    <= imem_addr;
              if_instr <= imem_rdata;
              if_valid <= 1'b1;
            end else begin
              // Output is held by stall: park the word and stop requesting
              // until the output drains.
              skid_pc    <= imem_addr;
              skid_instr <= imem_rdata;
              imem_req   <= 1'b0;
              state      <= S_FULL;
            end
          end else if (consume) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
          end
        end

        S_FULL: begin
          if (consume) begin
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
            if_valid <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_DROP: begin
          // fetch_pc already holds the redirect target; imem_addr still shows
          // the squashed address until the ack releases it.
          if (imem_ack) begin
            imem_addr <= fetch_pc;
            state     <= S_FETCH;
          end
        end

        default: begin
          state    <= S_FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'hE000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word at address a is a ^ A5A5.
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; checks and input changes happen 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 16'h0000;
    imem_ack    = 1'b0;

    // T1: reset values, request rises the cycle after release
    tick();
    tick();
    chk("rst_instr", if_instr, 16'hE000);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_req",   imem_req, 1'b0);
    chk("rst_addr",  imem_addr, 16'h0000);
    chk("rst_pc",    if_pc, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("t1_req",   imem_req, 1'b1);
    chk("t1_addr",  imem_addr, 16'h0000);
    chk("t1_valid", if_valid, 1'b0);

    // T2: zero-wait stream
    imem_ack = 1'b1;
    tick();
    chk("t2_pc0",    if_pc, 16'h0000);
    chk("t2_instr0", if_instr, 16'hA5A5);
    chk("t2_valid0", if_valid, 1'b1);
    tick();
    chk("t2_pc1",    if_pc, 16'h0001);
    chk("t2_instr1", if_instr, 16'hA5A4);
    tick();
    chk("t2_pc2",    if_pc, 16'h0002);
    chk("t2_instr2", if_instr, 16'hA5A7);

    // T3: stall 3 cycles at pc 2 with ack high -> instr 3 into skid
    stall = 1'b1;
    tick();
    chk("t3_hold_pc_a", if_pc, 16'h0002);
    chk("t3_req_off_a", imem_req, 1'b0);
    tick();
    chk("t3_hold_pc_b", if_pc, 16'h0002);
    chk("t3_req_off_b", imem_req, 1'b0);
    tick();
    chk("t3_hold_pc_c",    if_pc, 16'h0002);
    chk("t3_hold_instr_c", if_instr, 16'hA5A7);
    stall = 1'b0;
    tick();
    chk("t3_pc3",    if_pc, 16'h0003);
    chk("t3_instr3", if_instr, 16'hA5A6);
    chk("t3_req_on", imem_req, 1'b1);
    chk("t3_addr4",  imem_addr, 16'h0004);
    tick();
    chk("t3_pc4",    if_pc, 16'h0004);
    chk("t3_instr4", if_instr, 16'hA5A1);
    chk("t3_addr5",  imem_addr, 16'h0005);

    // T4: ack withheld, flush to 0040 while waiting
    imem_ack = 1'b0;
    tick();
    chk("t4_drain_valid", if_valid, 1'b0);
    chk("t4_drain_instr", if_instr, 16'hE000);
    chk("t4_wait_addr",   imem_addr, 16'h0005);
    flush       = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    flush = 1'b0;
    chk("t4_drop_addr",  imem_addr, 16'h0005);
    chk("t4_drop_req",   imem_req, 1'b1);
    chk("t4_drop_valid", if_valid, 1'b0);
    tick();
    chk("t4_still_addr", imem_addr, 16'h0005);
    imem_ack = 1'b1;
    tick();
    chk("t4_redir_addr", imem_addr, 16'h0040);
    chk("t4_drop_data",  if_valid, 1'b0);
    tick();
    chk("t4_pc40",    if_pc, 16'h0040);
    chk("t4_instr40", if_instr, 16'hA5E5);
    chk("t4_valid40", if_valid, 1'b1);

    // T5: flush + stall + ack on one edge, redirect 0100
    flush       = 1'b1;
    stall       = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("t5_valid", if_valid, 1'b0);
    chk("t5_instr", if_instr, 16'hE000);
    chk("t5_addr",  imem_addr, 16'h0100);
    tick();
    chk("t5_pc100",    if_pc, 16'h0100);
    chk("t5_instr100", if_instr, 16'hA4A5);

    // T6: wrap FFFF -> 0000, then reset mid-wait
    flush       = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    flush = 1'b0;
    chk("t6_addr_ffff", imem_addr, 16'hFFFF);
    chk("t6_flushed",   if_valid, 1'b0);
    tick();
    chk("t6_pc_ffff",    if_pc, 16'hFFFF);
    chk("t6_instr_ffff", if_instr, 16'h5A5A);
    chk("t6_addr_wrap",  imem_addr, 16'h0000);
    tick();
    chk("t6_pc_0000",    if_pc, 16'h0000);
    chk("t6_instr_0000", if_instr, 16'hA5A5);
    imem_ack = 1'b0;
    tick();
    chk("t6_wait_req",  imem_req, 1'b1);
    chk("t6_wait_addr", imem_addr, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   imem_req, 1'b0);
    chk("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_instr", if_instr, 16'hE000);
    chk("t6_rst_addr",  imem_addr, 16'h0000);
    chk("t6_rst_pc",    if_pc, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_rel_req",  imem_req, 1'b1);
    chk("t6_rel_addr", imem_addr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
